// File: rtl/serial_adder_pkg.sv
// Shared FSM state encoding and slice width for the serial nibble adder.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple adder: s = a + b + cin, s[4] is the carry-out.
import serial_adder_pkg::*;

module nibble_adder (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W:0]   s
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign s[NIBBLE_W] = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one nibble per clock, LSB first,
// through a single nibble_adder with a registered carry.
import serial_adder_pkg::*;

module serial_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_r, b_r;
  logic [WIDTH:0]      sum_q;
  logic [NIBBLE_W-1:0] a_nib, b_nib;
  logic [NIBBLE_W:0]   slice;
  logic                accept;
  logic                last;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign sum    = sum_q;
  assign accept = start && ready;
  assign last   = (idx_q == IW'(NIB - 1));

  // Nibble select as a decoded mux rather than a variable part-select.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_r[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_adder u_nibble_adder (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .s   (slice)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Subtraction is a + ~b + 1: b is inverted at capture and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else if (accept) begin
      a_r                <= a;
      b_r                <= sub ? ~b : b;
      carry_q            <= sub;
      idx_q              <= '0;
      sum_q[WIDTH-1:0]   <= '0;
    end else if (state_q == ST_RUN) begin
      carry_q <= slice[NIBBLE_W];
      idx_q   <= idx_q + IW'(1);
      for (int unsigned i = 0; i < NIB; i++) begin
        if (idx_q == IW'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice[NIBBLE_W-1:0];
      end
      if (last) sum_q[WIDTH] <= slice[NIBBLE_W];
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder: WIDTH=16 and WIDTH=4 instances checked every cycle
// against a cycle-count reference model, plus literal results for directed operations.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st [2];
  logic        sb [2];
  logic [15:0] aa [2];
  logic [15:0] bb [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [16:0] sum16;
  logic [4:0]  sum4;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .a(aa[0]), .b(bb[0]),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(sum16)
  );

  serial_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .a(aa[1][3:0]), .b(bb[1][3:0]),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(sum4)
  );

  // Reference model: an accepted op completes exactly W/4 edges later.
  int          m_rem  [2];
  logic        m_done [2];
  logic        m_valid[2];
  logic [16:0] m_res  [2];
  logic [16:0] m_sum  [2];
  int          m_acc  [2];
  logic        m_init = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [16:0] pin_q[$];

  function automatic logic [16:0] ref_res(int w, logic [15:0] x, logic [15:0] y, logic s);
    int unsigned mask, xm, ym, r;
    mask = (32'd1 << w) - 1;
    xm = 32'(x) & mask;
    ym = 32'(y) & mask;
    r  = s ? (xm + ((~ym) & mask) + 1) : (xm + ym);
    return 17'(r);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_done[k] = 1'b0; m_valid[k] = 1'b0;
      m_res[k] = '0; m_sum[k] = '0; m_acc[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 16 : 4;
      if (!rst_n) begin
        m_rem[k] <= 0; m_done[k] <= 1'b0; m_sum[k] <= '0; m_valid[k] <= 1'b1;
      end else if (m_rem[k] == 0 && st[k]) begin
        m_rem[k]   <= w / 4;
        m_res[k]   <= ref_res(w, aa[k], bb[k], sb[k]);
        m_done[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
        m_acc[k]   <= m_acc[k] + 1;
      end else if (m_rem[k] > 0) begin
        m_rem[k] <= m_rem[k] - 1;
        if (m_rem[k] == 1) begin
          m_done[k] <= 1'b1; m_sum[k] <= m_res[k]; m_valid[k] <= 1'b1;
        end
      end else begin
        m_done[k] <= 1'b0;
      end
    end
    if (!rst_n) m_init <= 1'b1;
  end

  task automatic chk(string name, int k, logic [16:0] act, logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        logic [16:0] act_sum;
        act_sum = (k == 0) ? sum16 : {12'b0, sum4};
        chk("ready", k, 17'(rdy[k]), 17'(m_rem[k] == 0));
        chk("busy",  k, 17'(bsy[k]), 17'(m_rem[k] != 0));
        chk("done",  k, 17'(dn[k]),  17'(m_done[k]));
        if (m_valid[k]) chk("sum", k, act_sum, m_sum[k]);
      end
      if (m_done[0] && pin_q.size() > 0) begin
        logic [16:0] exp;
        exp = pin_q.pop_front();
        chk("pin_model", 0, m_sum[0], exp);
        chk("pin_dut",   0, sum16,    exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op16(logic [15:0] x, logic [15:0] y, logic s, logic [16:0] exp);
    pin_q.push_back(exp);
    aa[0] = x; bb[0] = y; sb[0] = s; st[0] = 1'b1;
    step();
    st[0] = 1'b0; aa[0] = 16'($urandom); bb[0] = 16'($urandom); sb[0] = 1'($urandom);
    repeat (5) step();
  endtask

  initial begin
    int base0, base1, cyc;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; sb[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    op16(16'h1234, 16'h4321, 1'b0, 17'h05555);
    op16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    op16(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
    op16(16'h0005, 16'h0003, 1'b1, 17'h10002);
    op16(16'h0003, 16'h0005, 1'b1, 17'h0FFFE);

    // start pulsed while busy must be ignored
    pin_q.push_back(17'h00002);
    aa[0] = 16'h0001; bb[0] = 16'h0001; sb[0] = 1'b0; st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    step();
    aa[0] = 16'h1111; st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    repeat (3) step();

    // start held through the DONE cycle: back-to-back operation
    pin_q.push_back(17'h00300);
    pin_q.push_back(17'h00030);
    aa[0] = 16'h0100; bb[0] = 16'h0200; sb[0] = 1'b0; st[0] = 1'b1;
    step();
    aa[0] = 16'h0010; bb[0] = 16'h0020;
    repeat (5) step();
    st[0] = 1'b0;
    repeat (5) step();

    // reset asserted at the 2nd RUN edge aborts the op
    aa[0] = 16'h1234; bb[0] = 16'h4321; sb[0] = 1'b0; st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    op16(16'h1234, 16'h4321, 1'b0, 17'h05555);

    // randomised phase on both widths
    base0 = m_acc[0];
    base1 = m_acc[1];
    cyc = 0;
    while ((m_acc[0] - base0 < 1000 || m_acc[1] - base1 < 1000) && cyc < 60000) begin
      for (int k = 0; k < 2; k++) begin
        st[k] = ($urandom_range(0, 3) != 0);
        sb[k] = 1'($urandom);
        aa[k] = 16'($urandom);
        bb[k] = 16'($urandom);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
      cyc++;
    end
    for (int k = 0; k < 2; k++) st[k] = 1'b0;
    rst_n = 1'b1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
Name: serial_nibble_adder

Overview:
- Multi-cycle adder/subtractor for WIDTH-bit operands.
- Processes one 4-bit slice per clock, LSB first, through a combinational nibble adder with a registered carry.
- Sits directly upstream of the 4-bit adder datapath: it sequences operand nibbles into the adder and consumes the 5-bit slice result (4 sum bits plus carry).
- Lets lab designs add wide operands using only the 4-bit adder stage.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived number of nibble steps; not overridable.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; sampled only when ready=1.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- ready  output  1  block can accept start (state IDLE or DONE).
- busy  output  1  operation in progress (state RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH+1  result; bit WIDTH is the final carry-out.

Behaviour:
- Reset is synchronous and active-low: rst_n=0 at a rising clk edge is the only reset event.
  - state=IDLE, ready=1, busy=0, done=0, sum=0.
  - carry=0, slice index=0, operand registers=0.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the NIB-th slice.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Accept (edge E0, start=1 while ready=1):
  - latch a into A_r.
  - latch b into B_r, or ~b if sub=1.
  - carry <= sub; idx <= 0; sum[WIDTH-1:0] cleared; state <= RUN.
- RUN, each edge:
  - slice = nibble_adder(A_r[4*idx+:4], B_r[4*idx+:4], carry).
  - sum[4*idx+:4] <= slice[3:0]; carry <= slice[4]; idx <= idx+1.
  - On the edge with idx = NIB-1: sum[WIDTH] <= slice[4]; state <= DONE.
- Latency: done=1 in the cycle after edge E_NIB, i.e. NIB edges after acceptance (4 for WIDTH=16). done is high for exactly one cycle.
- sum holds its value after done until the next accepted start, which clears the low bits at acceptance.
- Subtraction uses two's complement, computed as a + ~b + 1.
  - sum[WIDTH]=1 means no borrow (a >= b unsigned).
  - sum[WIDTH-1:0] is always (a-b) mod 2^WIDTH.
- start while busy=1 is ignored: no queuing, operands unchanged, no error flag.
- Back-to-back: start=1 during the DONE cycle is accepted. done drops next cycle and RUN begins with no idle gap.
- a, b and sub may change freely after acceptance; only the latched copies are used.
- rst_n=0 mid-RUN:
  - next edge returns to IDLE with all outputs at reset values.
  - the partial result is discarded and no done pulse is produced.
- Reset has priority over start on the same edge.
- WIDTH=4 degenerates to a single RUN cycle; done follows one edge after acceptance.

Decomposition:
- Shared package (serial_adder_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NIBBLE_W=4.
- One sub-module, nibble_adder:
  - purely combinational, inputs a[3:0], b[3:0], cin; output s[4:0] = a+b+cin.
  - instantiated once; the structural full-adder chain of the existing 4-bit adder work is acceptable inside it.
- Top module holds the FSM, the index counter, the carry register and the result shift/write logic (~150-250 lines).

Test Plan:
- Add (WIDTH=16): a=16'h1234, b=16'h4321, sub=0 -> done 4 edges after accept; sum=17'h05555; busy=1 for exactly 4 cycles.
- Carry ripple across slices: a=16'hFFFF, b=16'h0001, sub=0 -> sum=17'h10000; a=16'hFFFF, b=16'hFFFF -> sum=17'h1FFFE.
- Subtract:
  - a=16'h0005, b=16'h0003, sub=1 -> sum=17'h10002 (no borrow).
  - a=16'h0003, b=16'h0005, sub=1 -> sum=17'h0FFFE (borrow).
- Protocol:
  - start pulsed with a=16'h1111 while busy during 16'h0001+16'h0001 -> ignored; sum=17'h00002.
  - start held through the DONE cycle with a=16'h0010, b=16'h0020 -> second done 4 edges later with sum=17'h00030.
- Reset: rst_n=0 at the 2nd RUN edge -> next cycle ready=1, busy=0, done=0, sum=0; no done pulse appears afterwards; a fresh op then completes correctly.
- Randomised 1000 ops, WIDTH=16 and WIDTH=4 -> sum matches the reference {carry, a±b} model on every done.
